// File: rtl/add16_seq_ctrl.sv
// Operand sequencing and result capture around a 16-bit ripple-carry adder.
// Define ADD16_SUB_EN to enable two's-complement subtraction via in_sub.
module add16_seq_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    input  logic        in_cin,
    input  logic        in_sub,
    output logic [15:0] add_a,
    output logic [15:0] add_b,
    output logic        add_cin,
    input  logic [15:0] add_sum,
    input  logic        add_cout,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_sum,
    output logic        out_cout,
    output logic        out_ovf
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [3:0]  cnt;
    logic        accept;
    logic        capture;
    logic [15:0] b_eff;
    logic        cin_eff;

`ifdef ADD16_SUB_EN
    assign b_eff   = in_sub ? ~in_b : in_b;
    assign cin_eff = in_sub | in_cin;
`else
    logic unused_sub;
    assign unused_sub = in_sub;
    assign b_eff      = in_b;
    assign cin_eff    = in_cin;
`endif

    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        capture  = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SETTLE: begin
                if (cnt == 4'd1) begin
                    capture  = 1'b1;
                    state_nx = HOLD;
                end
            end
            HOLD: begin
                in_ready = out_ready;
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        accept = in_valid & in_ready;
        if (accept) begin
            state_nx = SETTLE;
        end
    end

    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                cnt <= 4'(SETTLE_CYCLES);
            end else if (state == SETTLE) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Adder inputs only move on accept so the carry chain sees stable operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_a   <= 16'd0;
            add_b   <= 16'd0;
            add_cin <= 1'b0;
        end else if (accept) begin
            add_a   <= in_a;
            add_b   <= b_eff;
            add_cin <= cin_eff;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum  <= 16'd0;
            out_cout <= 1'b0;
            out_ovf  <= 1'b0;
        end else if (capture) begin
            out_sum  <= add_sum;
            out_cout <= add_cout;
            out_ovf  <= (add_a[15] == add_b[15]) &&
                        (add_sum[15] != add_a[15]);
        end
    end

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Scoreboard bench for add16_seq_ctrl with a behavioural adder attached.
// Honours ADD16_SUB_EN the same way as the design build.
module tb_add16_seq_ctrl;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = 16'd0;
    logic [15:0] in_b = 16'd0;
    logic        in_cin = 1'b0;
    logic        in_sub = 1'b0;
    logic [15:0] add_a;
    logic [15:0] add_b;
    logic        add_cin;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_sum;
    logic        out_cout;
    logic        out_ovf;

    add16_seq_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_sum(add_sum), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    // External combinational adder.
    always_comb begin
        {add_cout, add_sum} = 17'(add_a) + 17'(add_b) + 17'(add_cin);
    end

    typedef struct {
        logic [15:0] a;
        logic [15:0] be;
        logic        ce;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          edge_n;
    } exp_t;

    exp_t q[$];
    exp_t last_e;
    exp_t pend_e;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   acc_now = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)",
                     nm, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a,
                                   input logic [15:0] b,
                                   input logic cin, input logic sub,
                                   input int e);
        exp_t r;
        int   uv;
        int   sv;
        r.be = b;
        r.ce = cin;
        if (sub) begin
`ifdef ADD16_SUB_EN
            r.be = ~b;
            r.ce = 1'b1;
`endif
        end
        uv = int'(a) + int'(r.be) + int'(r.ce);
        sv = int'($signed(a)) + int'($signed(r.be)) + int'(r.ce);
        r.a = a;
        r.sum = uv[15:0];
        r.cout = uv[16];
        r.ovf = (sv > 32767) || (sv < -32768);
        r.edge_n = e;
        return r;
    endfunction

    // Stimulus side: record every accepted pair.
    always @(negedge clk) begin
        acc_now = 1'b0;
        if (rst_n && in_valid && in_ready) begin
            last_e = model(in_a, in_b, in_cin, in_sub, cyc + 1);
            q.push_back(last_e);
            acc_now = 1'b1;
        end
    end

    // Monitor.
    bit          prev_ov;
    bit          prev_ordy;
    bit          prev_acc;
    logic [15:0] p_a, p_b, p_sum;
    logic        p_c, p_cout, p_ovf;

    always @(negedge clk) begin
        #1;
        if (!rst_n) begin
            prev_ov = 0;
            prev_ordy = 0;
            prev_acc = 0;
            p_a = 0;
            p_b = 0;
            p_c = 0;
        end else begin
            bit   exp_rdy;
            exp_t e;
            if (out_valid) exp_rdy = out_ready;
            else exp_rdy = ((q.size() - int'(acc_now)) == 0);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            if (prev_acc) begin
                chk("add_a_load", 32'(add_a), 32'(pend_e.a));
                chk("add_b_load", 32'(add_b), 32'(pend_e.be));
                chk("add_cin_load", 32'(add_cin), 32'(pend_e.ce));
            end else begin
                chk("add_a_stable", 32'(add_a), 32'(p_a));
                chk("add_b_stable", 32'(add_b), 32'(p_b));
                chk("add_cin_stable", 32'(add_cin), 32'(p_c));
            end
            if (prev_ov && !prev_ordy) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_sum", 32'(out_sum), 32'(p_sum));
                chk("hold_cout", 32'(out_cout), 32'(p_cout));
                chk("hold_ovf", 32'(out_ovf), 32'(p_ovf));
            end
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = q[0];
                    if (!prev_ov) chk("latency", 32'(cyc - e.edge_n), 32'(S));
                    chk("sum", 32'(out_sum), 32'(e.sum));
                    chk("cout", 32'(out_cout), 32'(e.cout));
                    chk("ovf", 32'(out_ovf), 32'(e.ovf));
                    if (out_ready) void'(q.pop_front());
                end
            end else if (q.size() > int'(acc_now) &&
                         cyc - q[0].edge_n > S) begin
                chk("result_timeout", 32'(out_valid), 32'd1);
                void'(q.pop_front());
            end
            prev_ov = out_valid;
            prev_ordy = out_ready;
            prev_acc = acc_now;
            if (acc_now) pend_e = last_e;
            p_a = add_a;
            p_b = add_b;
            p_c = add_cin;
            p_sum = out_sum;
            p_cout = out_cout;
            p_ovf = out_ovf;
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic cin, input logic sub);
        bit ok;
        ok = 0;
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_cin = cin;
        in_sub = sub;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        chk("send_accept", 32'(ok), 32'd1);
        @(posedge clk);
        #2;
        in_valid = 1'b0;
    endtask

    task automatic wait_res(input string nm, input logic [15:0] s,
                            input logic c, input logic o);
        for (int t = 0; t < 20; t++) begin
            if (out_valid) break;
            @(negedge clk);
        end
        #2;
        chk({nm, "_valid"}, 32'(out_valid), 32'd1);
        chk({nm, "_sum"}, 32'(out_sum), 32'(s));
        chk({nm, "_cout"}, 32'(out_cout), 32'(c));
        chk({nm, "_ovf"}, 32'(out_ovf), 32'(o));
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({nm, "_out_sum"}, 32'(out_sum), 32'd0);
        chk({nm, "_out_cout"}, 32'(out_cout), 32'd0);
        chk({nm, "_out_ovf"}, 32'(out_ovf), 32'd0);
        chk({nm, "_add_a"}, 32'(add_a), 32'd0);
        chk({nm, "_add_b"}, 32'(add_b), 32'd0);
        chk({nm, "_add_cin"}, 32'(add_cin), 32'd0);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #12;
        chk_reset_vals("rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_res("ovf_pos", 16'h8000, 1'b0, 1'b1);
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_res("wrap", 16'h0000, 1'b1, 1'b0);
        send(16'h0000, 16'h0000, 1'b1, 1'b0);
        wait_res("cin_only", 16'h0001, 1'b0, 1'b0);

`ifdef ADD16_SUB_EN
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_res("sub_neg", 16'hFFFE, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_res("sub_ovf", 16'h7FFF, 1'b1, 1'b1);
`else
        send(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_res("sub_ign", 16'h000C, 1'b0, 1'b0);
        send(16'h8000, 16'h0001, 1'b0, 1'b1);
        wait_res("sub_ign2", 16'h8001, 1'b0, 1'b0);
`endif

        // Backpressure, then release with a pair already waiting.
        @(posedge clk);
        #2;
        out_ready = 1'b0;
        send(16'h1234, 16'h1111, 1'b0, 1'b0);
        wait_res("bp", 16'h2345, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        in_valid = 1'b1;
        in_a = 16'h4000;
        in_b = 16'h4000;
        in_cin = 1'b0;
        in_sub = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_valid", 32'(out_valid), 32'd1);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        chk("b2b_settle", 32'(out_valid), 32'd0);
        wait_res("b2b", 16'h8000, 1'b0, 1'b1);

        // Asynchronous reset during SETTLE.
        send(16'h00FF, 16'h0F00, 1'b1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        q.delete();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_idle", 32'(out_valid), 32'd0);

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            in_valid = 1'($urandom_range(0, 1));
            in_a = 16'($urandom);
            in_b = 16'($urandom);
            in_cin = 1'($urandom_range(0, 1));
            in_sub = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (S + 4) @(posedge clk);
        #3;
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/add16_seq_ctrl.md
# add16_seq_ctrl

Sequencing and capture stage wrapped around the 16-bit combinational ripple-carry adder. It accepts operand pairs over a valid/ready handshake, drives them onto the adder inputs through registers, and waits a fixed number of settle cycles for the carry chain to resolve. It then captures sum, carry-out and signed overflow into output registers presented over a second valid/ready handshake. Upstream feeds it operand words; the adder consumes its `add_*` outputs and returns its result to it.

## Interface
- `SETTLE_CYCLES`, default 2: clock edges between operand launch and result capture; legal range 1..15.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  stage can accept an operand pair.
- `in_a`  in  16  operand A.
- `in_b`  in  16  operand B.
- `in_cin`  in  1  carry-in.
- `in_sub`  in  1  subtract request; used only when `ADD16_SUB_EN` is defined, otherwise ignored.
- `add_a`  out  16  registered A to adder; bit i maps to adder `a<i>`.
- `add_b`  out  16  registered effective B to adder; bit i maps to adder `b<i>`.
- `add_cin`  out  1  registered carry-in to adder.
- `add_sum`  in  16  adder sum; bit i from adder `sum<i>`.
- `add_cout`  in  1  adder carry-out.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts result.
- `out_sum`  out  16  captured sum.
- `out_cout`  out  1  captured carry-out.
- `out_ovf`  out  1  captured signed overflow.

## Operation
- FSM states: IDLE, SETTLE, HOLD. Reset state is IDLE.
- Input handshake fires on a rising edge with `in_valid && in_ready`.
- `in_ready` is combinational: 1 in IDLE, and `out_ready` in HOLD. It is 0 in SETTLE.
- **IDLE, on accept:** latch `add_a=in_a`, `add_b=B_eff`, `add_cin=cin_eff`; load counter with `SETTLE_CYCLES`; go to SETTLE.
- **SETTLE:** decrement the counter each edge. On the edge where the counter equals 1, capture:
  - `out_sum=add_sum`, `out_cout=add_cout`
  - `out_ovf = (add_a[15]==add_b[15]) && (add_sum[15]!=add_a[15])`
  - go to HOLD.
- **HOLD:** `out_valid=1`; all `out_*` are held stable until `out_valid && out_ready`.
  - On that handshake with `in_valid=1`: accept the new pair as in IDLE and go directly to SETTLE.
  - With `in_valid=0`: go to IDLE.
- `add_*` registers hold their last value until the next accept, so they stay stable through SETTLE and HOLD.
- Arithmetic is modulo 2^16 and done by the external adder. This block computes only overflow, and computes it from registered values.
- Asserting `rst_n` low in any state aborts the operation immediately. No partial result is ever presented.

## Timing
- Reset values: `out_valid=0`, `out_sum=0`, `out_cout=0`, `out_ovf=0`, `add_a=0`, `add_b=0`, `add_cin=0`, counter 0, state IDLE (hence `in_ready=1`).
- Latency: accept at edge k gives `out_valid=1` after edge k+SETTLE_CYCLES.
- Throughput with `out_ready` tied high: one result per SETTLE_CYCLES+1 cycles. Back-to-back issue happens through HOLD.
- `out_valid` falls on the edge following the output handshake unless a new result is captured on that same edge. That cannot happen, because capture only occurs from SETTLE.
- The adder path between `add_*` and `add_sum`/`add_cout` must settle within SETTLE_CYCLES clock periods; this is a constraint on the integrator, not checked in RTL.

## Configuration
- `ADD16_SUB_EN` defined:
  - `B_eff = in_sub ? ~in_b : in_b`
  - `cin_eff = in_sub ? 1 : in_cin`
  - Overflow uses `B_eff`, so it is correct for two's-complement subtraction.
- `ADD16_SUB_EN` undefined: `B_eff=in_b`, `cin_eff=in_cin`, and `in_sub` is ignored.

## Test plan
- **Overflow, no carry:** reset, then `SETTLE_CYCLES=2`, accept A=0x7FFF, B=0x0001, cin=0 at edge k. Required: `out_valid` at k+2, sum=0x8000, cout=0, ovf=1.
- **Wrap-around:** A=0xFFFF, B=0x0001, cin=0 gives sum=0x0000, cout=1, ovf=0. A=0x0000, B=0x0000, cin=1 gives sum=0x0001, cout=0, ovf=0.
- **Backpressure:** hold `out_ready=0` for 5 cycles after `out_valid`. Required: `out_*` and `add_*` stable, `in_ready=0`. On release with `in_valid=1`, the next pair is accepted on the same edge and its result appears SETTLE_CYCLES edges later.
- **Reset mid-operation:** drop `rst_n` during SETTLE. Required: all outputs return to reset values asynchronously. After release, no `out_valid` until a new accept.
- **Subtraction, with `ADD16_SUB_EN`:** A=0x0005, B=0x0007, sub=1 gives sum=0xFFFE, cout=0, ovf=0. A=0x8000, B=0x0001, sub=1 gives sum=0x7FFF, cout=1, ovf=1. Without the macro, the same stimulus gives 0x000C and 0x8001 respectively.
